// File: rtl/axil_exec_pkg.sv
// Shared types and constants for the AXI4-Lite command executor.
// cmd_t / resp_t describe the default 32/32 ring word layouts.
package axil_exec_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic                     rw;
    logic [AXIL_DATA_W/8-1:0] strb;
    logic [AXIL_ADDR_W-1:0]   addr;
    logic [AXIL_DATA_W-1:0]   data;
  } cmd_t;

  typedef struct packed {
    logic [1:0]             resp;
    logic [AXIL_DATA_W-1:0] rdata;
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POP       = 3'd1,
    ST_POP_REL   = 3'd2,
    ST_AXI       = 3'd3,
    ST_PUSH_WAIT = 3'd4,
    ST_PUSH      = 3'd5,
    ST_PUSH_REL  = 3'd6
  } exec_state_e;

endpackage

// File: rtl/fourphase_master.sv
// Requester side of a four-phase req/ack handshake.
// done pulses while req and ack are both high; released pulses when ack falls afterwards.
module fourphase_master (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic done,
  output logic released
);

  logic req_q, req_d;
  logic rel_q, rel_d;

  always_comb begin
    req_d    = req_q;
    rel_d    = rel_q;
    done     = req_q & ack;
    released = rel_q & ~ack;
    if (done) begin
      req_d = 1'b0;
      rel_d = 1'b1;
    end else if (released) begin
      rel_d = 1'b0;
    end else if (start && !req_q && !rel_q) begin
      req_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      req_q <= req_d;
      rel_q <= rel_d;
    end
  end

  assign req = req_q;

endmodule

// File: rtl/axil_cmd_executor.sv
// Pops a command from the command ring, runs it as one AXI4-Lite read or write, pushes the response.
// Optional watchdog on the AXI phase: define AXIL_EXEC_TIMEOUT_EN.
//
// state        | meaning
// IDLE         | waiting for cmd_avail
// POP          | cmd_pop_req high, waiting for ack
// POP_REL      | req dropped, waiting for ack low
// AXI          | AXI-Lite transaction in flight
// PUSH_WAIT    | response captured, waiting for resp_space
// PUSH         | resp_push_req high, waiting for ack
// PUSH_REL     | req dropped, waiting for ack low
module axil_cmd_executor
  import axil_exec_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int CMD_W          = 1 + DATA_W/8 + ADDR_W + DATA_W,
  parameter int RESP_W         = 2 + DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_avail,
  output logic                cmd_pop_req,
  input  logic                cmd_pop_ack,
  input  logic [CMD_W-1:0]    cmd_pop_struct,
  input  logic                resp_space,
  output logic                resp_push_req,
  input  logic                resp_push_ack,
  output logic [RESP_W-1:0]   resp_push_struct,
  output logic [ADDR_W-1:0]   m_axil_awaddr,
  output logic [2:0]          m_axil_awprot,
  output logic                m_axil_awvalid,
  input  logic                m_axil_awready,
  output logic [DATA_W-1:0]   m_axil_wdata,
  output logic [DATA_W/8-1:0] m_axil_wstrb,
  output logic                m_axil_wvalid,
  input  logic                m_axil_wready,
  input  logic [1:0]          m_axil_bresp,
  input  logic                m_axil_bvalid,
  output logic                m_axil_bready,
  output logic [ADDR_W-1:0]   m_axil_araddr,
  output logic [2:0]          m_axil_arprot,
  output logic                m_axil_arvalid,
  input  logic                m_axil_arready,
  input  logic [DATA_W-1:0]   m_axil_rdata,
  input  logic [1:0]          m_axil_rresp,
  input  logic                m_axil_rvalid,
  output logic                m_axil_rready,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;

  // Reset asserts asynchronously but releases two clocks later, synchronous to clk.
  logic [1:0] rst_pipe_q, rst_pipe_d;
  logic       rst_int;

  assign rst_pipe_d = {rst_pipe_q[0], 1'b0};
  assign rst_int    = rst_pipe_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_pipe_q <= 2'b11;
    else       rst_pipe_q <= rst_pipe_d;
  end

  exec_state_e       state_q, state_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic pop_start, pop_done, pop_released;
  logic push_start, push_done, push_released;
  logic axi_complete;
  logic cmd_rw, aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign cmd_rw = cmd_q[CMD_W-1];
  assign aw_hs  = awvalid_q & m_axil_awready;
  assign w_hs   = wvalid_q  & m_axil_wready;
  assign b_hs   = bready_q  & m_axil_bvalid;
  assign ar_hs  = arvalid_q & m_axil_arready;
  assign r_hs   = rready_q  & m_axil_rvalid;

  fourphase_master u_pop (
    .clk      (clk),
    .reset    (rst_int),
    .start    (pop_start),
    .ack      (cmd_pop_ack),
    .req      (cmd_pop_req),
    .done     (pop_done),
    .released (pop_released)
  );

  fourphase_master u_push (
    .clk      (clk),
    .reset    (rst_int),
    .start    (push_start),
    .ack      (resp_push_ack),
    .req      (resp_push_req),
    .done     (push_done),
    .released (push_released)
  );

`ifdef AXIL_EXEC_TIMEOUT_EN
  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(TIMEOUT_DATA);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts AXI cycles only; any exit clears it so the next command starts from zero.
  always_comb begin
    tmo_d = '0;
    if (state_q == ST_AXI && state_d == ST_AXI) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    resp_d       = resp_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    pop_start    = 1'b0;
    push_start   = 1'b0;
    axi_complete = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_avail) begin
          state_d   = ST_POP;
          pop_start = 1'b1;
        end
      end
      ST_POP: begin
        if (pop_done) begin
          cmd_d   = cmd_pop_struct;
          state_d = ST_POP_REL;
        end
      end
      ST_POP_REL: begin
        if (pop_released) begin
          state_d   = ST_AXI;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (cmd_rw) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            arvalid_d = 1'b1;
          end
        end
      end
      ST_AXI: begin
        if (cmd_rw) begin
          if (aw_hs) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
          end
          if (w_hs) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
          end
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) bready_d = 1'b1;
          if (b_hs) begin
            bready_d     = 1'b0;
            resp_d       = {m_axil_bresp, {DATA_W{1'b0}}};
            axi_complete = 1'b1;
          end
        end else begin
          if (ar_hs) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
          end
          if (r_hs) begin
            rready_d     = 1'b0;
            resp_d       = {m_axil_rresp, m_axil_rdata};
            axi_complete = 1'b1;
          end
        end
        if (axi_complete) state_d = ST_PUSH_WAIT;
`ifdef AXIL_EXEC_TIMEOUT_EN
        // A completion in the same cycle wins over the watchdog.
        else if (tmo_q == TMO_LAST) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b0;
          arvalid_d = 1'b0;
          rready_d  = 1'b0;
          resp_d    = {AXI_DECERR, TMO_DATA};
          state_d   = ST_PUSH_WAIT;
        end
`endif
      end
      ST_PUSH_WAIT: begin
        if (resp_space) begin
          state_d    = ST_PUSH;
          push_start = 1'b1;
        end
      end
      ST_PUSH: begin
        if (push_done) state_d = ST_PUSH_REL;
      end
      ST_PUSH_REL: begin
        if (push_released) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      resp_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      resp_q    <= resp_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign resp_push_struct = resp_q;
  assign m_axil_awaddr    = cmd_q[ADDR_W+DATA_W-1 -: ADDR_W];
  assign m_axil_araddr    = cmd_q[ADDR_W+DATA_W-1 -: ADDR_W];
  assign m_axil_wdata     = cmd_q[DATA_W-1:0];
  assign m_axil_wstrb     = cmd_q[CMD_W-2 -: STRB_W];
  assign m_axil_awprot    = 3'b000;
  assign m_axil_arprot    = 3'b000;
  assign m_axil_awvalid   = awvalid_q;
  assign m_axil_wvalid    = wvalid_q;
  assign m_axil_bready    = bready_q;
  assign m_axil_arvalid   = arvalid_q;
  assign m_axil_rready    = rready_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axil_cmd_executor.sv
// Directed bench for axil_cmd_executor: ring responders and an AXI-Lite slave with programmable ready delays.
module tb_axil_cmd_executor;
  import axil_exec_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CMD_W  = 69;
  localparam int RESP_W = 34;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_avail = 1'b0, cmd_pop_req, cmd_pop_ack = 1'b0;
  logic [CMD_W-1:0]  cmd_pop_struct;
  logic              resp_space = 1'b1, resp_push_req, resp_push_ack = 1'b0;
  logic [RESP_W-1:0] resp_push_struct;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic [3:0]  m_axil_wstrb;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic m_axil_awvalid, m_axil_awready = 1'b0, m_axil_wvalid, m_axil_wready = 1'b0;
  logic m_axil_bvalid = 1'b0, m_axil_bready, m_axil_arvalid, m_axil_arready = 1'b0;
  logic m_axil_rvalid = 1'b0, m_axil_rready, busy;

  always #5 clk = ~clk;

  axil_cmd_executor #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_avail(cmd_avail), .cmd_pop_req(cmd_pop_req), .cmd_pop_ack(cmd_pop_ack),
    .cmd_pop_struct(cmd_pop_struct),
    .resp_space(resp_space), .resp_push_req(resp_push_req), .resp_push_ack(resp_push_ack),
    .resp_push_struct(resp_push_struct),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot), .m_axil_awvalid(m_axil_awvalid),
    .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
    .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot), .m_axil_arvalid(m_axil_arvalid),
    .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_axil_rready),
    .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  cmd_t cmd_word = '0;
  assign cmd_pop_struct = cmd_word;

  // Ring responders: ack follows req one cycle later.
  int pop_cnt = 0, push_cnt = 0;
  logic [RESP_W-1:0] last_resp = '0;

  initial forever begin
    @(posedge clk); #1;
    if (cmd_pop_req && !cmd_pop_ack) begin
      cmd_pop_ack = 1'b1;
      pop_cnt++;
    end else if (!cmd_pop_req) begin
      cmd_pop_ack = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (resp_push_req && !resp_push_ack) begin
      resp_push_ack = 1'b1;
      last_resp = resp_push_struct;
      push_cnt++;
    end else if (!resp_push_req) begin
      resp_push_ack = 1'b0;
    end
  end

  // AXI-Lite slave
  int aw_delay = 0, w_delay = 0, ar_delay = 0;
  int aw_wait = 0, w_wait = 0, ar_wait = 0;
  logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
  logic [31:0] rdata_val = '0;
  int aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0, b_hs_cnt = 0;
  int ar_high = 0, unstable = 0, bready_early = 0;
  logic w_drop_while_aw = 1'b0;
  logic aw_seen = 1'b0, w_seen = 1'b0, r_pend = 1'b0;
  logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_bv = 0, p_br = 0;
  logic p_arv = 0, p_arr = 0, p_rv = 0, p_rr = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
  logic [3:0]  p_wstrb = '0;
  logic [2:0]  p_awprot = '0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;
  logic [2:0]  cap_awprot = 3'b111;

  assign m_axil_bresp = bresp_val;
  assign m_axil_rresp = rresp_val;
  assign m_axil_rdata = rdata_val;

  initial forever begin
    @(posedge clk); #1;
    if (p_awv && p_awr) begin
      aw_hs_cnt++; aw_seen = 1'b1; cap_awaddr = p_awaddr; cap_awprot = p_awprot;
    end
    if (p_wv && p_wr) begin
      w_hs_cnt++; w_seen = 1'b1; cap_wdata = p_wdata; cap_wstrb = p_wstrb;
    end
    if (p_bv && p_br) begin
      b_hs_cnt++; m_axil_bvalid = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
    end else if (aw_seen && w_seen) begin
      m_axil_bvalid = 1'b1;
    end
    if (p_arv && p_arr) begin
      ar_hs_cnt++; r_pend = 1'b1; cap_araddr = p_araddr;
    end
    if (p_rv && p_rr) begin
      m_axil_rvalid = 1'b0; r_pend = 1'b0;
    end else if (r_pend) begin
      m_axil_rvalid = 1'b1;
    end
    if (p_awv && !p_awr && m_axil_awvalid && m_axil_awaddr != p_awaddr) unstable++;
    if (p_wv && !p_wr && m_axil_wvalid && m_axil_wdata != p_wdata) unstable++;
    if (p_arv && !p_arr && m_axil_arvalid && m_axil_araddr != p_araddr) unstable++;
    if (m_axil_bready && !(aw_seen && w_seen)) bready_early++;
    if (m_axil_awvalid && !m_axil_wvalid) w_drop_while_aw = 1'b1;
    if (m_axil_arvalid) ar_high++;
    if (m_axil_awvalid) begin m_axil_awready = (aw_wait >= aw_delay); aw_wait++; end
    else begin m_axil_awready = 1'b0; aw_wait = 0; end
    if (m_axil_wvalid) begin m_axil_wready = (w_wait >= w_delay); w_wait++; end
    else begin m_axil_wready = 1'b0; w_wait = 0; end
    if (m_axil_arvalid) begin m_axil_arready = (ar_wait >= ar_delay); ar_wait++; end
    else begin m_axil_arready = 1'b0; ar_wait = 0; end
    p_awv = m_axil_awvalid; p_awr = m_axil_awready; p_awaddr = m_axil_awaddr; p_awprot = m_axil_awprot;
    p_wv = m_axil_wvalid; p_wr = m_axil_wready; p_wdata = m_axil_wdata; p_wstrb = m_axil_wstrb;
    p_bv = m_axil_bvalid; p_br = m_axil_bready;
    p_arv = m_axil_arvalid; p_arr = m_axil_arready; p_araddr = m_axil_araddr;
    p_rv = m_axil_rvalid; p_rr = m_axil_rready;
  end

  task automatic send_cmd(input cmd_t c);
    int n0 = pop_cnt;
    int k = 0;
    cmd_word = c;
    cmd_avail = 1'b1;
    while (pop_cnt == n0 && k < 50) begin @(negedge clk); k++; end
    cmd_avail = 1'b0;
    chk_val("pop_seen", 64'(pop_cnt - n0), 1);
  endtask

  task automatic wait_push(input int n0);
    int k = 0;
    while (push_cnt == n0 && k < 200) begin @(negedge clk); k++; end
    chk_val("push_seen", 64'(push_cnt - n0), 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 50) begin @(negedge clk); k++; end
    chk_val("idle", 64'(busy), 0);
  endtask

  function automatic cmd_t mk_cmd(logic rw, logic [3:0] strb, logic [31:0] addr, logic [31:0] data);
    cmd_t c;
    c.rw = rw; c.strb = strb; c.addr = addr; c.data = data;
    return c;
  endfunction

  logic any_out;
  assign any_out = |{cmd_pop_req, resp_push_req, resp_push_struct, m_axil_awaddr, m_axil_awprot,
                     m_axil_awvalid, m_axil_wdata, m_axil_wstrb, m_axil_wvalid, m_axil_bready,
                     m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready, busy};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n0, a0, w0, bad, k;

    // reset state
    repeat (3) @(negedge clk);
    chk_val("reset_outputs", 64'(any_out), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 1: write, zero-wait handshakes, OKAY
    a0 = aw_hs_cnt; w0 = w_hs_cnt; n0 = push_cnt;
    aw_delay = 0; w_delay = 0; bresp_val = AXI_OKAY;
    send_cmd(mk_cmd(1'b1, 4'hF, 32'h0000_0010, 32'hA5A5_0001));
    wait_push(n0);
    chk_val("wr_aw_beats", 64'(aw_hs_cnt - a0), 1);
    chk_val("wr_w_beats", 64'(w_hs_cnt - w0), 1);
    chk_val("wr_awaddr", cap_awaddr, 32'h0000_0010);
    chk_val("wr_awprot", cap_awprot, 0);
    chk_val("wr_wdata", cap_wdata, 32'hA5A5_0001);
    chk_val("wr_wstrb", cap_wstrb, 4'hF);
    chk_val("wr_resp", last_resp, {2'b00, 32'h0});
    wait_idle();

    // 2: read, arready delayed 3 cycles
    n0 = push_cnt; ar_high = 0; unstable = 0;
    ar_delay = 3; rdata_val = 32'h1234_5678; rresp_val = AXI_OKAY;
    send_cmd(mk_cmd(1'b0, 4'h0, 32'h0000_0020, 32'h0));
    wait_push(n0);
    chk_val("rd_ar_cycles", 64'(ar_high), 4);
    chk_val("rd_unstable", 64'(unstable), 0);
    chk_val("rd_araddr", cap_araddr, 32'h0000_0020);
    chk_val("rd_resp", last_resp, {2'b00, 32'h1234_5678});
    wait_idle();

    // 3: W accepted 2 cycles before AW, SLVERR passed through
    n0 = push_cnt; a0 = aw_hs_cnt; w0 = w_hs_cnt;
    w_drop_while_aw = 1'b0; bready_early = 0; unstable = 0;
    aw_delay = 2; w_delay = 0; bresp_val = AXI_SLVERR;
    send_cmd(mk_cmd(1'b1, 4'h3, 32'h0000_0040, 32'h0BAD_F00D));
    wait_push(n0);
    chk_val("ooo_w_dropped_first", 64'(w_drop_while_aw), 1);
    chk_val("ooo_bready_early", 64'(bready_early), 0);
    chk_val("ooo_unstable", 64'(unstable), 0);
    chk_val("ooo_beats", 64'((aw_hs_cnt - a0) * 10 + (w_hs_cnt - w0)), 11);
    chk_val("ooo_wstrb", cap_wstrb, 4'h3);
    chk_val("ooo_resp", last_resp, {2'b10, 32'h0});
    repeat (5) @(negedge clk);
    chk_val("ooo_single_push", 64'(push_cnt - n0), 1);
    wait_idle();

    // 4: response ring full for 10 cycles after B
    n0 = push_cnt; a0 = b_hs_cnt;
    aw_delay = 0; bresp_val = AXI_EXOKAY; resp_space = 1'b0;
    send_cmd(mk_cmd(1'b1, 4'hF, 32'h0000_0080, 32'h1111_2222));
    k = 0;
    while (b_hs_cnt == a0 && k < 50) begin @(negedge clk); k++; end
    chk_val("full_b_done", 64'(b_hs_cnt - a0), 1);
    cmd_avail = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_push_req || !busy || cmd_pop_req) bad++;
    end
    chk_val("full_stall", 64'(bad), 0);
    cmd_avail = 1'b0;
    resp_space = 1'b1;
    wait_push(n0);
    chk_val("full_resp", last_resp, {2'b01, 32'h0});
    wait_idle();

    // 5: reset while arvalid is high
    ar_delay = 1000;
    send_cmd(mk_cmd(1'b0, 4'h0, 32'h0000_00C0, 32'h0));
    k = 0;
    while (!m_axil_arvalid && k < 20) begin @(negedge clk); k++; end
    chk_val("mid_arvalid", 64'(m_axil_arvalid), 1);
    n0 = push_cnt;
    reset = 1'b1;
    #1;
    chk_val("mid_reset_outputs", 64'(any_out), 0);
    aw_seen = 1'b0; w_seen = 1'b0; r_pend = 1'b0;
    m_axil_bvalid = 1'b0; m_axil_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ar_delay = 0; rdata_val = 32'hCAFE_F00D; rresp_val = AXI_OKAY;
    repeat (6) @(negedge clk);
    chk_val("no_stale_push", 64'(push_cnt - n0), 0);
    send_cmd(mk_cmd(1'b0, 4'h0, 32'h0000_0030, 32'h0));
    wait_push(n0);
    chk_val("post_rst_araddr", cap_araddr, 32'h0000_0030);
    chk_val("post_rst_resp", last_resp, {2'b00, 32'hCAFE_F00D});
    wait_idle();

`ifdef AXIL_EXEC_TIMEOUT_EN
    // 6: watchdog on a read that never gets arready
    n0 = push_cnt; ar_high = 0; ar_delay = 100000;
    send_cmd(mk_cmd(1'b0, 4'h0, 32'h0000_0100, 32'h0));
    wait_push(n0);
    chk_val("tmo_ar_cycles", 64'(ar_high), TMO);
    chk_val("tmo_resp", last_resp, {2'b11, 32'hDEAD_BEEF});
    wait_idle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
